// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch granule,
// the buffered entry layout and PC alignment.
package fetch_pkg;

    localparam int FETCH_PC_WIDTH   = 32;
    localparam int FETCH_INST_WIDTH = 32;
    localparam int INST_BYTES       = 4;

    typedef struct packed {
        logic [FETCH_INST_WIDTH-1:0] inst;
        logic [FETCH_PC_WIDTH-1:0]   pc;
    } fetch_entry_t;

    function automatic logic [FETCH_PC_WIDTH-1:0] pc_align(input logic [FETCH_PC_WIDTH-1:0] pc);
        return {pc[FETCH_PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetched entries; the head is kept in its own register so
// decode sees a registered value with no extra read latency.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  entry_t                  push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output entry_t                  head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    entry_t      mem [DEPTH];
    entry_t      head_reg;
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [AW:0] rd_ptr_inc;
    logic        do_push;
    logic        do_pop;

    assign count      = wr_ptr_reg - rd_ptr_reg;
    assign do_push    = push && !flush;
    assign do_pop     = pop && !flush && (count != '0);
    assign rd_ptr_inc = rd_ptr_reg + ONE;
    assign head       = head_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            // Next head is either the stored successor or the entry arriving now
            if (do_pop && (count > ONE)) begin
                head_reg <= mem[rd_ptr_inc[AW-1:0]];
            end else if (do_push && ((count == '0) || (do_pop && (count == ONE)))) begin
                head_reg <= push_data;
            end
        end
    end

endmodule

// File: rtl/stage_if_prefetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited memory requests,
// buffers tagged responses and squashes in-flight work on redirect.
module stage_if_prefetch
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  INST_WIDTH   = 32,
    parameter int                  FIFO_DEPTH   = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    output logic                  o_MemReq,
    output logic [PC_WIDTH-1:0]   o_MemAddr,
    input  logic                  i_MemReqReady,
    input  logic                  i_MemRspValid,
    input  logic [INST_WIDTH-1:0] i_MemRspInst,
    input  logic                  i_Redirect,
    input  logic [PC_WIDTH-1:0]   i_RedirectPC,
    output logic                  o_Valid,
    output logic [INST_WIDTH-1:0] o_Inst,
    output logic [PC_WIDTH-1:0]   o_PC,
    input  logic                  i_Ready
);

    localparam int                  CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(INST_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INST_BYTES - 1);

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [PC_WIDTH-1:0]   pc;
    } entry_t;

    logic [PC_WIDTH-1:0] fetch_pc_reg;
    logic [PC_WIDTH-1:0] rsp_pc_reg;
    logic [CW-1:0]       outstanding_reg;
    logic [CW-1:0]       discard_reg;
    logic [CW-1:0]       count;
    logic [CW:0]         in_use;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                req_fire;
    logic                rsp_accept;
    logic                push;
    logic                pop;
    entry_t              push_data;
    entry_t              head;

    // Credit covers both buffered entries and requests still in flight
    assign in_use      = {1'b0, outstanding_reg} + {1'b0, count};
    assign o_MemReq    = i_Reset && !i_Redirect && (in_use < (CW+1)'(FIFO_DEPTH));
    assign o_MemAddr   = fetch_pc_reg & ALIGN_MASK;
    assign redirect_pc = i_RedirectPC & ALIGN_MASK;

    assign req_fire    = o_MemReq && i_MemReqReady;
    assign rsp_accept  = i_MemRspValid && (outstanding_reg != '0);
    assign push        = !i_Redirect && rsp_accept && (discard_reg == '0);
    assign pop         = !i_Redirect && o_Valid && i_Ready;
    assign push_data   = '{inst: i_MemRspInst, pc: rsp_pc_reg};

    assign o_Valid     = (count != '0);
    assign o_Inst      = head.inst;
    assign o_PC        = head.pc;

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            fetch_pc_reg    <= RESET_VECTOR;
            rsp_pc_reg      <= RESET_VECTOR;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else if (i_Redirect) begin
            fetch_pc_reg    <= redirect_pc;
            rsp_pc_reg      <= redirect_pc;
            outstanding_reg <= outstanding_reg - CW'(rsp_accept);
            discard_reg     <= outstanding_reg - CW'(rsp_accept);
        end else begin
            if (req_fire) begin
                fetch_pc_reg <= fetch_pc_reg + PC_STEP;
            end
            if (push) begin
                rsp_pc_reg <= rsp_pc_reg + PC_STEP;
            end
            if (rsp_accept && (discard_reg != '0)) begin
                discard_reg <= discard_reg - CW'(1);
            end
            outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(rsp_accept);
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (i_Clock),
        .rst_n     (i_Reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (i_Redirect),
        .count     (count),
        .head      (head)
    );

    rsp_without_request: assert property (@(posedge i_Clock) disable iff (!i_Reset)
        !(i_MemRspValid && (outstanding_reg == '0)));

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Bench for stage_if_prefetch: an in-order memory model plus an epoch-tagged
// reference of the decode stream, compared every cycle, with literal anchors.
module tb_stage_if_prefetch;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        i_Clock       = 1'b0;
    logic        i_Reset       = 1'b1;
    logic        o_MemReq;
    logic [31:0] o_MemAddr;
    logic        i_MemReqReady = 1'b0;
    logic        i_MemRspValid = 1'b0;
    logic [31:0] i_MemRspInst  = '0;
    logic        i_Redirect    = 1'b0;
    logic [31:0] i_RedirectPC  = '0;
    logic        o_Valid;
    logic [31:0] o_Inst;
    logic [31:0] o_PC;
    logic        i_Ready       = 1'b0;

    stage_if_prefetch #(
        .PC_WIDTH     (32),
        .INST_WIDTH   (32),
        .FIFO_DEPTH   (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .o_MemReq      (o_MemReq),
        .o_MemAddr     (o_MemAddr),
        .i_MemReqReady (i_MemReqReady),
        .i_MemRspValid (i_MemRspValid),
        .i_MemRspInst  (i_MemRspInst),
        .i_Redirect    (i_Redirect),
        .i_RedirectPC  (i_RedirectPC),
        .o_Valid       (o_Valid),
        .o_Inst        (o_Inst),
        .o_PC          (o_PC),
        .i_Ready       (i_Ready)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct { logic [31:0] addr; int due;   } mem_req_t;
    typedef struct { logic [31:0] addr; int epoch; } flight_t;
    typedef struct { logic [31:0] pc;   logic [31:0] inst; } entry_m_t;

    mem_req_t    mem_q[$];
    flight_t     flight_q[$];
    entry_m_t    buf_q[$];
    logic [31:0] req_log[$];

    logic [31:0] m_fetch;
    int          epoch = 0;
    int          cyc = 0;
    int          first_valid = -1;
    logic [31:0] first_pop_pc = '0;
    bit          seen_pop = 0;
    int          pops = 0;
    int          n_total = 0;
    int          n_pass = 0;

    bit          k_mem_ready = 1;
    bit          k_ready = 1;
    bit          k_redir = 0;
    logic [31:0] k_redir_pc = '0;
    int          k_lat = 1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a ^ 32'hA5A5_0000) + 32'h0000_1013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle: drive inputs after the falling edge, compare, then advance the model
    task automatic step();
        bit          rsp_now;
        bit          m_req;
        bit          m_valid;
        bit          dut_fire;
        bit          pop_now;
        logic [31:0] dut_addr;
        entry_m_t    hd;
        entry_m_t    ne;
        flight_t     fl;
        mem_req_t    mr;

        rsp_now = 1'b0;
        if (mem_q.size() != 0) rsp_now = (mem_q[0].due <= cyc);
        i_MemReqReady = k_mem_ready;
        i_Ready       = k_ready;
        i_Redirect    = k_redir;
        i_RedirectPC  = k_redir_pc;
        i_MemRspValid = rsp_now;
        i_MemRspInst  = rsp_now ? inst_of(mem_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        m_req   = !k_redir && ((flight_q.size() + buf_q.size()) < DEPTH);
        m_valid = (buf_q.size() != 0);
        chk("mem_req", 32'(o_MemReq), 32'(m_req));
        chk("mem_addr", o_MemAddr, m_fetch);
        chk("valid", 32'(o_Valid), 32'(m_valid));
        if (m_valid) begin
            hd = buf_q[0];
            chk("head_pc", o_PC, hd.pc);
            chk("head_inst", o_Inst, hd.inst);
        end
        if (o_Valid && first_valid < 0) first_valid = cyc;
        dut_fire = o_MemReq && k_mem_ready;
        dut_addr = o_MemAddr;
        pop_now  = m_valid && k_ready && !k_redir;
        if (pop_now) begin
            $display("cycle %0d decode pc=0x%08h inst=0x%08h", cyc, o_PC, o_Inst);
            if (!seen_pop) begin
                first_pop_pc = o_PC;
                seen_pop = 1;
            end
            pops++;
        end

        @(posedge i_Clock);
        if (pop_now) void'(buf_q.pop_front());
        if (rsp_now) begin
            void'(mem_q.pop_front());
            if (flight_q.size() != 0) begin
                fl = flight_q.pop_front();
                if (!k_redir && fl.epoch == epoch) begin
                    ne.pc   = fl.addr;
                    ne.inst = inst_of(fl.addr);
                    buf_q.push_back(ne);
                end
            end
        end
        if (k_redir) begin
            buf_q.delete();
            epoch++;
            m_fetch = pc_align(k_redir_pc);
            req_log.delete();
            seen_pop = 0;
        end
        if (dut_fire) begin
            mr.addr = dut_addr;
            mr.due  = cyc + k_lat;
            mem_q.push_back(mr);
            req_log.push_back(dut_addr);
        end
        if (m_req && k_mem_ready) begin
            fl.addr  = m_fetch;
            fl.epoch = epoch;
            flight_q.push_back(fl);
            m_fetch += 32'd4;
        end
        cyc++;
        @(negedge i_Clock);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases on a falling edge
    task automatic do_reset();
        #2;
        i_Reset = 1'b0;
        #1;
        chk("rst_mem_req", 32'(o_MemReq), 32'd0);
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_addr", o_MemAddr, RV);
        chk("rst_inst", o_Inst, 32'd0);
        chk("rst_pc", o_PC, 32'd0);
        i_Redirect    = 1'b0;
        i_MemRspValid = 1'b0;
        i_MemReqReady = 1'b0;
        i_Ready       = 1'b0;
        @(posedge i_Clock);
        @(negedge i_Clock);
        mem_q.delete();
        flight_q.delete();
        buf_q.delete();
        req_log.delete();
        epoch++;
        m_fetch     = RV;
        cyc         = 0;
        first_valid = -1;
        seen_pop    = 0;
        pops        = 0;
        k_redir     = 0;
        i_Reset     = 1'b1;
    endtask

    initial begin
        int guard;

        // Streaming with a one-cycle memory
        do_reset();
        run(12);
        chk("t1_first_valid", 32'(first_valid), 32'd2);
        chk("t1_req0", req_log[0], 32'h0);
        chk("t1_req1", req_log[1], 32'h4);
        chk("t1_req2", req_log[2], 32'h8);
        chk("t1_req3", req_log[3], 32'hC);
        chk("t1_pops", 32'(pops), 32'd10);

        // Decode stalled: credit stops after four requests
        k_ready = 0;
        do_reset();
        run(10);
        chk("t2_nreq", 32'(req_log.size()), 32'd4);
        chk("t2_req3", req_log[3], 32'hC);
        chk("t2_req_held", 32'(o_MemReq), 32'd0);
        k_ready = 1;
        step();
        chk("t2_pop_pc", first_pop_pc, 32'h0);
        k_ready = 0;
        step();
        chk("t2_nreq5", 32'(req_log.size()), 32'd5);
        chk("t2_req4", req_log[4], 32'h10);
        run(3);

        // Redirect with three slow requests in flight
        k_ready = 1;
        k_lat = 5;
        do_reset();
        run(3);
        chk("t3_inflight", 32'(req_log.size()), 32'd3);
        k_redir = 1;
        k_redir_pc = 32'h100;
        step();
        k_redir = 0;
        chk("t3_empty_after", 32'(o_Valid), 32'd0);
        run(20);
        chk("t3_seen", 32'(seen_pop), 32'd1);
        chk("t3_first_pc", first_pop_pc, 32'h100);

        // Redirect coinciding with a response and a pop
        k_lat = 2;
        run(8);
        guard = 0;
        while (!(mem_q.size() != 0 && mem_q[0].due <= cyc && buf_q.size() != 0) && guard < 20) begin
            step();
            guard++;
        end
        chk("t4_setup", 32'(guard < 20), 32'd1);
        k_redir = 1;
        k_redir_pc = 32'h400;
        step();
        k_redir = 0;
        chk("t4_empty_after", 32'(o_Valid), 32'd0);
        run(15);
        chk("t4_first_pc", first_pop_pc, 32'h400);

        // Unaligned target and address wrap
        k_lat = 1;
        k_redir = 1;
        k_redir_pc = 32'h203;
        step();
        k_redir = 0;
        chk("t5_addr", o_MemAddr, 32'h200);
        run(6);
        chk("t5_first_pc", first_pop_pc, 32'h200);
        k_redir = 1;
        k_redir_pc = 32'hFFFF_FFF8;
        step();
        k_redir = 0;
        run(8);
        chk("t5_wrap0", req_log[0], 32'hFFFF_FFF8);
        chk("t5_wrap1", req_log[1], 32'hFFFF_FFFC);
        chk("t5_wrap2", req_log[2], 32'h0000_0000);
        chk("t5_wrap3", req_log[3], 32'h0000_0004);
        chk("t5_first_pc_wrap", first_pop_pc, 32'hFFFF_FFF8);

        // Reset with the buffer full, then restart
        k_ready = 0;
        run(8);
        chk("t6_full_valid", 32'(o_Valid), 32'd1);
        do_reset();
        k_ready = 1;
        run(6);
        chk("t6_restart_addr", req_log[0], RV);
        chk("t6_restart_pc", first_pop_pc, RV);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
